fetch_stage: RTL

Instruction fetch stage of the pipelined MIPS core: the producer side of the IF/ID interface. It holds the program counter and issues requests to instruction memory. It registers the fetched instruction and its next-PC into the IF/ID pipeline register, and applies the redirect that decode computes, using MIPS single-delay-slot semantics. It absorbs memory latency and decode stalls with a one-entry skid buffer and a pending-redirect register.

---
 rtl/fetch_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch stage with IF/ID register, skid buffer and delay-slot redirect
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hz_if_stall,
    input  logic        id_if_selpcsource,
    input  logic [1:0]  id_if_selpctype,
    input  logic [31:0] id_if_pcimd2ext,
    input  logic [31:0] id_if_rega,
    input  logic [31:0] id_if_pcindex,
    output logic        if_mc_req,
    output logic [31:0] if_mc_addr,
    input  logic        mc_if_ack,
    input  logic [31:0] mc_if_data,
    output logic [31:0] if_id_instruc,
    output logic [31:0] if_id_nextpc
);

    // Skid holds one fetched word while decode is stalled.
    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_t;

    // A redirect whose delay slot has not yet returned from memory.
    typedef enum logic {
        REDIR_IDLE = 1'b0,
        REDIR_PEND = 1'b1
    } redir_state_t;

    localparam logic [1:0] SEL_BRANCH = 2'b00;
    localparam logic [1:0] SEL_REG    = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_SEQ    = 2'b11;

    skid_state_t  skid_state_q, skid_state_d;
    redir_state_t redir_state_q, redir_state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_nextpc_q, skid_nextpc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_nextpc_q, ifid_nextpc_d;

    logic        fetch_ok;
    logic        avail;
    logic        redir;
    logic [31:0] pc_inc;
    logic [31:0] redir_target;

    // A new request is only issued when there is room to park its result.
    assign if_mc_req  = (skid_state_q == SKID_EMPTY) && !reset;
    assign if_mc_addr = pc_q;

    assign fetch_ok = if_mc_req && mc_if_ack;
    assign avail    = (skid_state_q == SKID_FULL) || fetch_ok;
    assign pc_inc   = pc_q + 32'd1;
    assign redir    = id_if_selpcsource && (id_if_selpctype != SEL_SEQ);

    assign if_id_instruc = ifid_instr_q;
    assign if_id_nextpc  = ifid_nextpc_q;

    // Redirect target select; the sequential code never reaches the PC because redir is low.
    always_comb begin
        redir_target = pc_inc;
        case (id_if_selpctype)
            SEL_BRANCH: redir_target = id_if_pcimd2ext;
            SEL_REG:    redir_target = id_if_rega;
            SEL_JUMP:   redir_target = id_if_pcindex;
            default:    redir_target = pc_inc;
        endcase
    end

    // IF/ID register and skid buffer: hold on stall, drain skid first, else take memory or insert a nop.
    always_comb begin
        skid_state_d  = skid_state_q;
        skid_instr_d  = skid_instr_q;
        skid_nextpc_d = skid_nextpc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_nextpc_d = ifid_nextpc_q;

        if (hz_if_stall) begin
            if (fetch_ok) begin
                skid_state_d  = SKID_FULL;
                skid_instr_d  = mc_if_data;
                skid_nextpc_d = pc_inc;
            end
        end else if (skid_state_q == SKID_FULL) begin
            ifid_instr_d  = skid_instr_q;
            ifid_nextpc_d = skid_nextpc_q;
            skid_state_d  = SKID_EMPTY;
        end else if (fetch_ok) begin
            ifid_instr_d  = mc_if_data;
            ifid_nextpc_d = pc_inc;
        end else begin
            // Bubble: the all-zero word is sll $0,$0,0 and never redirects.
            ifid_instr_d  = 32'h0000_0000;
            ifid_nextpc_d = 32'h0000_0000;
        end
    end

    // PC and pending redirect: redirect as the delay slot enters IF/ID, or defer until it arrives.
    always_comb begin
        pc_d          = pc_q;
        redir_state_d = redir_state_q;
        redir_pc_d    = redir_pc_q;

        if (!hz_if_stall && redir && avail) begin
            // Delay slot is moving into IF/ID now, so the next fetch is the target.
            pc_d          = redir_target;
            redir_state_d = REDIR_IDLE;
        end else if (!hz_if_stall && redir) begin
            // Delay slot still in flight; the PC must stay put while its request is unacked.
            redir_state_d = REDIR_PEND;
            redir_pc_d    = redir_target;
        end else if (fetch_ok) begin
            pc_d          = (redir_state_q == REDIR_PEND) ? redir_pc_q : pc_inc;
            redir_state_d = REDIR_IDLE;
        end
    end

    // State registers; reset abandons any outstanding request, skid word and pending redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            skid_state_q  <= SKID_EMPTY;
            skid_instr_q  <= 32'h0000_0000;
            skid_nextpc_q <= 32'h0000_0000;
            redir_state_q <= REDIR_IDLE;
            redir_pc_q    <= 32'h0000_0000;
            ifid_instr_q  <= 32'h0000_0000;
            ifid_nextpc_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            skid_state_q  <= skid_state_d;
            skid_instr_q  <= skid_instr_d;
            skid_nextpc_q <= skid_nextpc_d;
            redir_state_q <= redir_state_d;
            redir_pc_q    <= redir_pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_nextpc_q <= ifid_nextpc_d;
        end
    end

endmodule
